// File: rtl/or_led_pkg.sv
// Shared constants and types for the OR/LED stretch bank.
package or_led_pkg;

  // Default geometry matching the original 14-input, 7-LED board layout
  localparam int unsigned DEF_NUM_CH      = 7;
  localparam int unsigned DEF_GROUP       = 2;
  localparam int unsigned DEF_HOLD_W      = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 10;
  localparam int unsigned DEF_CNT_W       = 8;

  // Capture mode encodings
  localparam int unsigned CAP_TRANSPARENT = 0;  // reload on every trigger
  localparam int unsigned CAP_FIRST_HIT   = 1;  // keep first capture until cleared

  // Capture state machine
  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/or_led_stretch_bank_stretch.sv
// Single-channel LED pulse stretcher: reloads on activity, counts down to zero.
module led_stretch #(
  parameter int unsigned HOLD_W      = 4,
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic act,
  output logic led
);

  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] ONE    = HOLD_W'(1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  // Next count: activity reloads, otherwise decay towards zero and stop
  always_comb begin
    cnt_d = cnt_q;
    if (act) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign led = (cnt_q != '0);

endmodule

// File: rtl/or_led_stretch_bank.sv
// OR/LED stretch bank: NUM_CH grouped-OR channels each driving a stretched
// LED, plus one trigger-gated capture LED and a saturating trigger-edge count.
// Optional macro OR_LED_INPUT_SYNC_EN inserts a 2-flop input synchronizer.
module or_led_stretch_bank
  import or_led_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned GROUP       = DEF_GROUP,
  parameter int unsigned HOLD_W      = DEF_HOLD_W,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned CAP_MODE    = CAP_TRANSPARENT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*GROUP-1:0] in,
  input  logic                    clr_capture,
  output logic [NUM_CH:0]         o_led,
  output logic [CNT_W-1:0]        o_trig_cnt
);

  localparam int unsigned     IN_W    = NUM_CH * GROUP;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [IN_W-1:0]   in_s;
  logic [IN_W-1:0]   in_q;
  logic [NUM_CH-1:0] or_ch;
  logic              trig;
  logic              cap_d_bit;
  logic              trig_q;
  logic              cap_q;
  cap_state_e        state_q;
  logic [CNT_W-1:0]  trig_cnt_q;

`ifdef OR_LED_INPUT_SYNC_EN
  logic [IN_W-1:0] sync1_q, sync2_q;

  // Two-stage synchronizer for inputs arriving from an unrelated domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = in;
`endif

  // Input sampling register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= '0;
    end else begin
      in_q <= in_s;
    end
  end

  // Per-channel OR reduction over each GROUP-bit slice
  always_comb begin
    or_ch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      or_ch[i] = |in_q[i*GROUP +: GROUP];
    end
  end

  // Trigger is all bits of channel 0; capture data is the top input bit
  assign trig      = &in_q[GROUP-1:0];
  assign cap_d_bit = in_q[IN_W-1];

  // One stretcher per channel LED
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_stretch #(
      .HOLD_W      (HOLD_W),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_stretch (
      .clk (clk),
      .rst (rst),
      .act (or_ch[g]),
      .led (o_led[g])
    );
  end

  // Capture FSM, trigger edge detect and saturating edge counter.
  // The edge history register updates even while clearing, so a trigger
  // level spanning the clear is never counted afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      cap_q      <= 1'b0;
      trig_q     <= 1'b0;
      trig_cnt_q <= '0;
    end else begin
      trig_q <= trig;
      if (clr_capture) begin
        cap_q      <= 1'b0;
        state_q    <= EMPTY;
        trig_cnt_q <= '0;
      end else begin
        if (trig && !trig_q && (trig_cnt_q != CNT_MAX)) begin
          trig_cnt_q <= trig_cnt_q + CNT_ONE;
        end
        if (CAP_MODE == CAP_TRANSPARENT) begin
          state_q <= EMPTY;
          if (trig) begin
            cap_q <= cap_d_bit;
          end
        end else begin
          case (state_q)
            EMPTY: begin
              if (trig) begin
                cap_q   <= cap_d_bit;
                state_q <= HELD;
              end
            end
            HELD: begin
              cap_q <= cap_q;
            end
            default: begin
              state_q <= EMPTY;
            end
          endcase
        end
      end
    end
  end

  assign o_led[NUM_CH] = cap_q;
  assign o_trig_cnt    = trig_cnt_q;

endmodule

// File: tb/tb_or_led_stretch_bank.sv
// Scoreboard bench: stimulus queues expected outputs tagged with the cycle
// they must appear in; monitors pop and compare on the falling edge, and a
// separate monitor checks the asynchronous reset response.
module tb_or_led_stretch_bank;

`ifdef OR_LED_INPUT_SYNC_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif

  typedef struct {
    int         cyc;
    bit         sel;
    logic [7:0] led;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] in0 = '0;
  logic [13:0] in1 = '0;
  logic        clr0 = 1'b0;
  logic        clr1 = 1'b0;
  logic [7:0]  led0, led1, cnt0, cnt1;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t rq[$];
  exp_t e_m, e_r;

  or_led_stretch_bank #(
    .NUM_CH(7), .GROUP(2), .HOLD_W(4), .HOLD_CYCLES(10), .CAP_MODE(0), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in(in0), .clr_capture(clr0), .o_led(led0), .o_trig_cnt(cnt0)
  );

  or_led_stretch_bank #(
    .NUM_CH(7), .GROUP(2), .HOLD_W(4), .HOLD_CYCLES(10), .CAP_MODE(1), .CNT_W(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in(in1), .clr_capture(clr1), .o_led(led1), .o_trig_cnt(cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-tagged monitor
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_m = q.pop_front();
      n_cmp++;
      if (e_m.cyc != cyc) begin
        n_err++;
        $display("FAIL %s: check for cycle %0d reached at cycle %0d", e_m.name, e_m.cyc, cyc);
      end else if ((e_m.sel ? led1 : led0) !== e_m.led || (e_m.sel ? cnt1 : cnt0) !== e_m.cnt) begin
        n_err++;
        $display("FAIL %s (dut%0d cyc %0d): got led=%h cnt=%0d, expected led=%h cnt=%0d",
                 e_m.name, e_m.sel, cyc, e_m.sel ? led1 : led0, e_m.sel ? cnt1 : cnt0,
                 e_m.led, e_m.cnt);
      end
    end
  end

  // Asynchronous reset monitor: checks shortly after rst rises, no clock edge
  always @(posedge rst) begin
    #1;
    while (rq.size() > 0) begin
      e_r = rq.pop_front();
      n_cmp++;
      if ((e_r.sel ? led1 : led0) !== e_r.led || (e_r.sel ? cnt1 : cnt0) !== e_r.cnt) begin
        n_err++;
        $display("FAIL %s (dut%0d): got led=%h cnt=%0d, expected led=%h cnt=%0d",
                 e_r.name, e_r.sel, e_r.sel ? led1 : led0, e_r.sel ? cnt1 : cnt0,
                 e_r.led, e_r.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int off, input bit sel, input logic [7:0] led,
                           input logic [7:0] cnt, input string nm);
    exp_t e;
    e.cyc = cyc + off; e.sel = sel; e.led = led; e.cnt = cnt; e.name = nm;
    q.push_back(e);
  endtask

  task automatic expect_rst(input bit sel, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.led = 8'h00; e.cnt = 8'h00; e.name = nm;
    rq.push_back(e);
  endtask

  task automatic drive(input bit sel, input logic [13:0] v);
    if (sel) in1 = v;
    else     in0 = v;
  endtask

  // One-cycle input pulse; pl/pc before effect, ml/mc while stretched, el after
  task automatic trig_seq(input bit sel, input logic [13:0] v,
                          input logic [7:0] pl, input logic [7:0] pc,
                          input logic [7:0] ml, input logic [7:0] mc,
                          input logic [7:0] el, input string nm);
    drive(sel, v);
    for (int k = 1; k <= 12; k++)
      expect_at(k + XL, sel, (k == 1) ? pl : ((k <= 11) ? ml : el), (k == 1) ? pc : mc, nm);
    tick();
    drive(sel, '0);
    tick(16);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      in0 = 14'h0003;
      tick();
      in0 = 14'h0000;
      tick();
    end
  endtask

  initial begin
    // Reset state
    tick();
    expect_at(0, 0, 8'h00, 8'h00, "reset0");
    expect_at(0, 1, 8'h00, 8'h00, "reset1");
    tick();
    rst = 1'b0;
    tick(2);

    // Single-cycle pulse on in[4] stretches LED 2 for exactly 10 cycles
    trig_seq(0, 14'h0010, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, "pulse_ch2");

    // Transparent capture: load 1, then reload with 0
    trig_seq(0, 14'h2003, 8'h00, 8'h00, 8'hC1, 8'h01, 8'h80, "cap0_hit");
    trig_seq(0, 14'h0003, 8'h80, 8'h01, 8'h01, 8'h02, 8'h00, "cap0_reload");

    // First-hit capture: second trigger does not overwrite
    trig_seq(1, 14'h2003, 8'h00, 8'h00, 8'hC1, 8'h01, 8'h80, "cap1_hit");
    trig_seq(1, 14'h0003, 8'h80, 8'h01, 8'h81, 8'h02, 8'h80, "cap1_frozen");

    // Clear, then recapture
    expect_at(0, 1, 8'h80, 8'h02, "pre_clr");
    clr1 = 1'b1;
    expect_at(1, 1, 8'h00, 8'h00, "clr_cap");
    tick();
    clr1 = 1'b0;
    tick(4);
    trig_seq(1, 14'h2003, 8'h00, 8'h00, 8'hC1, 8'h01, 8'h80, "cap1_recap");

    // Clear coinciding with trigger rising edge; held level must not count
    drive(1, 14'h0003);
    tick(1 + XL);
    clr1 = 1'b1;
    expect_at(1, 1, 8'h01, 8'h00, "clr_vs_trig");
    tick();
    clr1 = 1'b0;
    for (int k = 1; k <= 5; k++) expect_at(k, 1, 8'h01, 8'h00, "trig_held");
    drive(1, '0);
    expect_at(10 + XL, 1, 8'h01, 8'h00, "held_decay_last");
    expect_at(11 + XL, 1, 8'h00, 8'h00, "held_decay_off");
    tick(16);

    // Saturation of the trigger edge counter
    expect_at(0, 0, 8'h00, 8'h02, "pre_clr0");
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    expect_at(0, 0, 8'h00, 8'h00, "clr0_cnt");
    tick();
    pulses(100);
    tick(16);
    expect_at(0, 0, 8'h00, 8'd100, "cnt_100");
    tick();
    pulses(200);
    tick(16);
    expect_at(0, 0, 8'h00, 8'd255, "cnt_sat");
    tick();

    // Async reset mid-stretch (counter=5) with DUT1 in HELD
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    tick(2);
    drive(1, 14'h2003);
    tick();
    drive(1, '0);
    tick(5 + XL);
    expect_at(0, 1, 8'hC1, 8'h01, "pre_rst");
    tick();
    expect_rst(0, "async_rst0");
    expect_rst(1, "async_rst1");
    rst = 1'b1;
    #2;
    in0 = 14'h0010;
    tick(2);
    expect_at(0, 0, 8'h00, 8'h00, "rst_hold0");
    expect_at(0, 1, 8'h00, 8'h00, "rst_hold1");
    tick();
    rst = 1'b0;
    expect_at(1, 0, 8'h00, 8'h00, "post_rst_first");
    expect_at(2 + XL, 0, 8'h04, 8'h00, "post_rst_led");
    tick(3 + XL);
    in0 = 14'h0000;
    tick(16);

    if (q.size() + rq.size() != 0) begin
      n_err += q.size() + rq.size();
      $display("FAIL leftover: got %0d unchecked entries, expected 0", q.size() + rq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/or_led_stretch_bank.md
Name: or_led_stretch_bank

Overview:
- Parametrised successor to the fixed 14-input pairwise-OR LED driver.
- NUM_CH channels; each ORs a group of GROUP input bits and drives one LED through a per-channel pulse stretcher, so single-cycle activity stays visible.
- One extra LED shows a trigger-gated capture bit, with a selectable capture mode and a saturating trigger-edge counter.
- Sits between board switches/GPIO inputs and the LED bank.

Parameters:
- NUM_CH, 7, number of OR channels / stretched LEDs.
- GROUP, 2, input bits ORed per channel (>=2).
- HOLD_W, 4, stretch counter width.
- HOLD_CYCLES, 10, LED on-time after last active cycle (1..2^HOLD_W-1).
- CAP_MODE, 0, 0 = transparent capture (reload on every trigger); 1 = first-hit hold until cleared.
- CNT_W, 8, trigger-edge counter width.

Ports:
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- in  in  NUM_CH*GROUP  raw input bits.
- clr_capture  in  1  sync clear of capture bit, capture state and trigger counter.
- o_led  out  NUM_CH+1  [NUM_CH-1:0] stretched channel LEDs; [NUM_CH] capture bit.
- o_trig_cnt  out  CNT_W  saturating count of trigger rising edges.

Behaviour:
- Reset (async, rst=1): in_q=0, all stretch counters=0, cap_reg=0, cap_state=EMPTY, trig_q=0, o_trig_cnt=0. Hence o_led=0.
- Input stage: in_q <= in every cycle. or_ch[i] = |in_q[i*GROUP +: GROUP].
- Stretch, per channel:
  - If or_ch[i]=1, cnt_i <= HOLD_CYCLES.
  - Else if cnt_i != 0, cnt_i <= cnt_i-1.
  - o_led[i] = (cnt_i != 0).
  - Latency: in rising before edge k -> in_q at k -> LED high after edge k+1.
  - After the last active cycle the LED stays high exactly HOLD_CYCLES cycles.
  - Continuous activity holds the LED high indefinitely; the counter never wraps.
- Trigger: trig = &in_q[GROUP-1:0] (all bits of channel 0). Capture data: d = in_q[NUM_CH*GROUP-1].
- Capture state machine (2 states), evaluated in priority order each cycle:
  - clr_capture=1: cap_reg<=0, state<=EMPTY, o_trig_cnt<=0. A trigger in the same cycle is ignored and not counted.
  - CAP_MODE=0: state stays EMPTY; trig=1 -> cap_reg<=d; else cap_reg holds (gen-1 behaviour).
  - CAP_MODE=1, EMPTY: trig=1 -> cap_reg<=d, state<=HELD.
  - CAP_MODE=1, HELD: cap_reg frozen; further triggers still counted.
- Trigger counter:
  - trig_q <= trig every cycle, including during clr.
  - Rising edge (trig & ~trig_q) increments o_trig_cnt, saturating at 2^CNT_W-1 (no wrap).
  - A level held high counts once.
- o_led[NUM_CH] = cap_reg. Capture latency: in at edge k -> cap_reg after edge k+1.
- rst asserted mid-stretch or mid-hold clears immediately (async); first valid sample is on the first edge after deassertion.

Optional Feature:
- Macro OR_LED_INPUT_SYNC_EN.
- Defined: a 2-flop synchronizer (reset to 0) precedes in_q. All input-to-LED, capture and counter latencies grow by 2 cycles.
- Undefined: in is assumed synchronous to clk, and latencies are as stated above.

Decomposition:
- Package or_led_pkg: default constants (NUM_CH, GROUP, HOLD_CYCLES, CNT_W), CAP_MODE encodings, and the cap_state enum {EMPTY, HELD}.
- Sub-module led_stretch: one channel's counter (params HOLD_W, HOLD_CYCLES; ports clk, rst, act, led). The top level instantiates it NUM_CH times via generate.

Test Plan:
- Defaults. Single-cycle pulse in[4]=1 -> o_led[2] rises 2 cycles later, high exactly 10 cycles, then 0; other LEDs stay 0.
- in[0]=in[1]=1 for 1 cycle, in[13]=1 -> o_led[7]=1 and o_led[0] stretched. Repeat with in[13]=0 -> o_led[7]=0 (CAP_MODE=0). o_trig_cnt=2.
- CAP_MODE=1. Trigger with in[13]=1, then trigger with in[13]=0 -> o_led[7] stays 1. Pulse clr_capture -> o_led[7]=0 and o_trig_cnt=0. Next trigger recaptures.
- clr_capture and a trigger rising edge in the same cycle -> cap_reg=0, count stays 0. Holding trig high afterwards does not count.
- 300 trigger edges with CNT_W=8 -> o_trig_cnt saturates at 255.
- Assert rst mid-stretch (counter=5) and in HELD -> all outputs 0 immediately, without a clock edge. With OR_LED_INPUT_SYNC_EN, the pulse test shows a 4-cycle latency.
